// File: rtl/gated_window_integrator.sv
// ---------------------------------------------------------------------------
// gated_window_integrator
//
// Integrates a programmable window of signed ADC samples after each accepted
// trigger. A trigger is accepted on its rising edge when the interleaver gate
// (output_en) is high, the block is idle and the requested window is non-empty.
// After `delay` cycles the block sums `win_len` consecutive samples and offers
// the result over a valid/ready handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   trigger      trigger strobe (level; only the rising edge matters)
//   output_en    gate from the interleaver, synchronous to clk
//   delay        cycles from acceptance to first summed sample (latched)
//   win_len      number of samples summed (latched)
//   adc_data     signed ADC sample
//   sum_data     signed window sum, stable while sum_valid is high
//   sum_valid    result available
//   sum_ready    consumer accepts the result
//   busy         high while in DELAY or INTEG
//   overrun      sticky: a finished result was dropped
//   clr_overrun  synchronous clear of overrun (a simultaneous set wins)
//   trig_missed  one-cycle pulse when a trigger edge is ignored
// ---------------------------------------------------------------------------
module gated_window_integrator #(
    parameter int DATA_W  = 14,
    parameter int DELAY_W = 8,
    parameter int WIN_W   = 8,
    parameter int SUM_W   = DATA_W + WIN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trigger,
    input  logic                     output_en,
    input  logic [DELAY_W-1:0]       delay,
    input  logic [WIN_W-1:0]         win_len,
    input  logic signed [DATA_W-1:0] adc_data,
    output logic signed [SUM_W-1:0]  sum_data,
    output logic                     sum_valid,
    input  logic                     sum_ready,
    output logic                     busy,
    output logic                     overrun,
    input  logic                     clr_overrun,
    output logic                     trig_missed
);

    // One counter serves both the delay and the window phase.
    localparam int CNT_W = (DELAY_W > WIN_W) ? DELAY_W : WIN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        INTEG = 2'd2
    } state_t;

    state_t                   state;
    logic                     trig_d;
    logic [CNT_W-1:0]         cnt;
    logic [WIN_W-1:0]         win_q;
    logic signed [SUM_W-1:0]  acc;

    logic                     trig_edge;
    logic signed [SUM_W-1:0]  adc_ext;
    logic signed [SUM_W-1:0]  sum_next;
    logic                     done;
    logic                     transfer;

    assign trig_edge = trigger & ~trig_d;
    // Size cast of a signed operand sign-extends to the accumulator width.
    assign adc_ext   = SUM_W'(adc_data);
    assign sum_next  = acc + adc_ext;
    // Last sample of the window is being taken this cycle.
    assign done      = (state == INTEG) && (cnt == CNT_W'(1));
    assign transfer  = sum_valid & sum_ready;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order inside the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            trig_d      <= 1'b0;
            cnt         <= '0;
            win_q       <= '0;
            acc         <= '0;
            sum_data    <= '0;
            sum_valid   <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            trig_missed <= 1'b0;
        end else begin
            trig_d      <= trigger;
            trig_missed <= 1'b0;

            case (state)
                IDLE: begin
                    // Gated-off edges are silently ignored (normal case).
                    if (trig_edge && output_en) begin
                        if (win_len == '0) begin
                            trig_missed <= 1'b1;
                        end else begin
                            win_q <= win_len;
                            acc   <= '0;
                            busy  <= 1'b1;
                            if (delay == '0) begin
                                state <= INTEG;
                                cnt   <= CNT_W'(win_len);
                            end else begin
                                state <= DELAY;
                                cnt   <= CNT_W'(delay);
                            end
                        end
                    end
                end

                DELAY: begin
                    if (trig_edge) trig_missed <= 1'b1;
                    // cnt==1 on the last delay cycle; the next cycle samples.
                    if (cnt == CNT_W'(1)) begin
                        state <= INTEG;
                        cnt   <= CNT_W'(win_q);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                INTEG: begin
                    if (trig_edge) trig_missed <= 1'b1;
                    acc <= sum_next;
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Output register: a completion may reload it only when the slot
            // is empty or is being emptied by a transfer on this same cycle.
            if (done && (!sum_valid || sum_ready)) begin
                sum_data  <= sum_next;
                sum_valid <= 1'b1;
            end else if (transfer) begin
                sum_valid <= 1'b0;
            end

            // Set has priority over clear.
            if (done && sum_valid && !sum_ready) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gated_window_integrator.sv
// ---------------------------------------------------------------------------
// Testbench for gated_window_integrator. Stimulus pushes expected window sums
// into a queue; a negedge monitor pops and compares on every transfer and
// checks that a stalled result stays stable.
// ---------------------------------------------------------------------------
module tb_gated_window_integrator;

    localparam int DATA_W  = 14;
    localparam int DELAY_W = 8;
    localparam int WIN_W   = 8;
    localparam int SUM_W   = DATA_W + WIN_W;

    logic                     clk;
    logic                     rst_n;
    logic                     trigger;
    logic                     output_en;
    logic [DELAY_W-1:0]       delay;
    logic [WIN_W-1:0]         win_len;
    logic signed [DATA_W-1:0] adc_data;
    logic signed [SUM_W-1:0]  sum_data;
    logic                     sum_valid;
    logic                     sum_ready;
    logic                     busy;
    logic                     overrun;
    logic                     clr_overrun;
    logic                     trig_missed;

    int checks = 0;
    int errors = 0;

    logic signed [63:0] exp_q[$];
    logic               hold_pending = 1'b0;
    logic signed [63:0] hold_val = '0;

    gated_window_integrator #(
        .DATA_W (DATA_W),
        .DELAY_W(DELAY_W),
        .WIN_W  (WIN_W),
        .SUM_W  (SUM_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trigger    (trigger),
        .output_en  (output_en),
        .delay      (delay),
        .win_len    (win_len),
        .adc_data   (adc_data),
        .sum_data   (sum_data),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .busy       (busy),
        .overrun    (overrun),
        .clr_overrun(clr_overrun),
        .trig_missed(trig_missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare every transferred result, and hold-stability while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 64'(sum_valid), 64'd1);
                check("hold_data", sum_data, hold_val);
            end
            if (sum_valid && sum_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d expected none", sum_data);
                end else begin
                    check("sum_data", sum_data, exp_q.pop_front());
                end
            end
            hold_pending = sum_valid && !sum_ready;
            hold_val     = sum_data;
        end
    end

    // Issue one trigger and drive the window. adc_data is `pre` during the
    // delay, `val` for exactly the summed samples, `post` afterwards.
    // chk_lat: sum_valid must be low one cycle before completion.
    // ready_last: raise sum_ready during the completion cycle.
    // push_exp: the result is expected to reach the consumer.
    task automatic run_window(input string tag, input int d, input int w,
                              input int pre, input int val, input int post,
                              input bit chk_lat, input bit ready_last,
                              input bit push_exp);
        @(posedge clk);
        #1;
        delay    = DELAY_W'(d);
        win_len  = WIN_W'(w);
        adc_data = DATA_W'(pre);
        trigger  = 1'b1;
        if (push_exp) exp_q.push_back(64'(val) * 64'(w));
        @(posedge clk);                       // acceptance edge
        #1;
        trigger = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        repeat (d) @(posedge clk);
        if (d > 0) #1;
        adc_data = DATA_W'(val);
        repeat (w - 1) @(posedge clk);
        if (w > 1) #1;
        if (chk_lat) check({tag, "_early_valid"}, 64'(sum_valid), 64'd0);
        if (ready_last) sum_ready = 1'b1;
        @(posedge clk);                       // completion edge
        #1;
        adc_data = DATA_W'(post);
        check({tag, "_valid"}, 64'(sum_valid), 64'd1);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        if (sum_ready) begin
            @(posedge clk);
            #1;
            check({tag, "_valid_drop"}, 64'(sum_valid), 64'd0);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!sum_valid && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_timeout"}, 64'(sum_valid), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        trigger     = 1'b0;
        output_en   = 1'b1;
        delay       = '0;
        win_len     = '0;
        adc_data    = '0;
        sum_ready   = 1'b1;
        clr_overrun = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum_valid", 64'(sum_valid), 64'd0);
        check("rst_sum_data", sum_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_trig_missed", 64'(trig_missed), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic window: valid 7 edges after acceptance (cycle T+8), 400.
        run_window("basic", 3, 4, 0, 100, 0, 1'b1, 1'b0, 1'b1);
        // Delay alignment: wrong sample boundaries would pull in +/-1000.
        run_window("align", 2, 3, 1000, 5, -1000, 1'b1, 1'b0, 1'b1);
        // Signed: -8192 twice with no delay.
        run_window("neg", 0, 2, 0, -8192, 0, 1'b1, 1'b0, 1'b1);
        // Largest window of largest positive sample: 2088705.
        run_window("max", 0, 255, 0, 8191, 0, 1'b1, 1'b0, 1'b1);

        // Gating: trigger with output_en low does nothing.
        @(posedge clk);
        #1;
        output_en = 1'b0;
        delay     = 8'd0;
        win_len   = 8'd3;
        adc_data  = 14'sd7;
        trigger   = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("gate_busy", 64'(busy), 64'd0);
            check("gate_missed", 64'(trig_missed), 64'd0);
            check("gate_valid", 64'(sum_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        output_en = 1'b1;
        run_window("gate_on", 1, 3, 0, 7, 0, 1'b1, 1'b0, 1'b1);

        // Zero-length window: missed pulse, no result.
        @(posedge clk);
        #1;
        win_len = 8'd0;
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        check("zero_missed", 64'(trig_missed), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check("zero_missed_pulse", 64'(trig_missed), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("zero_no_valid", 64'(sum_valid), 64'd0);

        // Trigger during INTEG: one missed pulse, result unaffected (300).
        @(posedge clk);
        #1;
        delay    = 8'd0;
        win_len  = 8'd6;
        adc_data = 14'sd50;
        trigger  = 1'b1;
        exp_q.push_back(64'd300);
        @(posedge clk);
        #1;
        trigger = 1'b0;
        check("integ_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        check("integ_missed", 64'(trig_missed), 64'd1);
        @(posedge clk);
        #1;
        check("integ_missed_pulse", 64'(trig_missed), 64'd0);
        wait_valid("integ", 20);

        // Backpressure: first result held, second dropped, overrun set.
        sum_ready = 1'b0;
        run_window("bp_a", 1, 2, 0, 11, 0, 1'b1, 1'b0, 1'b1);
        run_window("bp_b", 0, 3, 0, 33, 0, 1'b0, 1'b0, 1'b0);
        check("bp_overrun", 64'(overrun), 64'd1);
        check("bp_held_data", sum_data, 64'd22);
        clr_overrun = 1'b1;
        @(posedge clk);
        #1;
        clr_overrun = 1'b0;
        check("bp_overrun_clr", 64'(overrun), 64'd0);
        // Completion coincides with transfer of the held result.
        run_window("bp_c", 0, 4, 0, -3, 0, 1'b0, 1'b1, 1'b1);
        check("bp_c_no_overrun", 64'(overrun), 64'd0);

        // Reset mid-INTEG aborts the window; sum_data is non-zero beforehand.
        @(posedge clk);
        #1;
        delay    = 8'd0;
        win_len  = 8'd10;
        adc_data = 14'sd9;
        trigger  = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(sum_valid), 64'd0);
        check("mid_rst_data", sum_data, 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_overrun", 64'(overrun), 64'd0);
        check("mid_rst_missed", 64'(trig_missed), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("post_rst_no_valid", 64'(sum_valid), 64'd0);
        run_window("post_rst", 2, 5, 0, -123, 0, 1'b1, 1'b0, 1'b1);

        // Drain: every expected result must have been consumed.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
